// File: rtl/seq_mult_param_if.sv
// Handshake and operand bundle for the sequential multiplier.
interface seq_mult_param_if #(
  parameter int WIDTH = 8
);
  logic               Start;
  logic               Signed_Mode;
  logic               Chain;
  logic [WIDTH-1:0]   Multiplicand;
  logic [WIDTH-1:0]   Multiplier;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] Product;
  logic               X;

  modport master (
    output Start, Signed_Mode, Chain,
    output Multiplicand, Multiplier,
    input  Busy, Done, Product, X
  );

  modport slave (
    input  Start, Signed_Mode, Chain,
    input  Multiplicand, Multiplier,
    output Busy, Done, Product, X
  );
endinterface

// File: rtl/seq_mult_param.sv
// Add-shift multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Chain mode reuses the low product half as the next multiplier.
module seq_mult_param #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input logic         Clk,
  input logic         Reset,
  seq_mult_param_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ADD, SHIFT, HOLD
  } state_t;

  localparam logic [CW:0] LAST = (CW+1)'(WIDTH-1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic             x_q, sm_q;
  logic             fin_q, done_q;
  logic [CW:0]      cnt_q;
  logic             last, sub;
  logic [WIDTH:0]   ea, em, sum;

  assign last = cnt_q == LAST;
  assign sub  = sm_q && last;
  assign ea   = {sm_q & a_q[WIDTH-1], a_q};
  assign em   = {sm_q & m_q[WIDTH-1], m_q};
  assign sum  = sub ? ea - em : ea + em;

  assign bus.Busy    = state_q == ADD || state_q == SHIFT;
  assign bus.Done    = done_q;
  assign bus.Product = {a_q, b_q};
  assign bus.X       = x_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.Start) state_d = ADD;
      ADD:   state_d = SHIFT;
      SHIFT: state_d = last ? HOLD : ADD;
      // stay until Done has pulsed and Start is released
      HOLD:  if (!bus.Start && !fin_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      sm_q    <= 1'b0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= state_q == SHIFT && last;
      done_q  <= fin_q;
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            m_q   <= bus.Multiplicand;
            sm_q  <= bus.Signed_Mode;
            a_q   <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
            if (!bus.Chain) b_q <= bus.Multiplier;
          end
        end
        ADD: begin
          if (b_q[0]) {x_q, a_q} <= sum;
        end
        SHIFT: begin
          x_q   <= sm_q & x_q;
          a_q   <= {x_q, a_q[WIDTH-1:1]};
          b_q   <= {a_q[0], b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
        HOLD: ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// Randomised and directed bench for seq_mult_param at WIDTH 8 and 4.
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mult_param_if #(.WIDTH(8)) b8();
  seq_mult_param_if #(.WIDTH(4)) b4();

  seq_mult_param #(.WIDTH(8)) u8 (
    .Clk(clk), .Reset(rst_n), .bus(b8)
  );
  seq_mult_param #(.WIDTH(4)) u4 (
    .Clk(clk), .Reset(rst_n), .bus(b4)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mb8;
  logic [3:0] mb4;

  function automatic logic [15:0] ref8(bit sm, logic [7:0] a, logic [7:0] b);
    longint x, y;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction

  function automatic logic [7:0] ref4(bit sm, logic [3:0] a, logic [3:0] b);
    longint x, y;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    return 8'(x * y);
  endfunction

  task automatic op8(input bit sm, input bit ch,
                     input logic [7:0] mc, input logic [7:0] mr,
                     input int hold, input int nk,
                     output logic [15:0] p, output logic x,
                     output int lat, output int busyc,
                     output int donec, output logic [15:0] pend);
    @(negedge clk);
    b8.Start = 1'b1; b8.Signed_Mode = sm; b8.Chain = ch;
    b8.Multiplicand = mc; b8.Multiplier = mr;
    @(posedge clk);
    lat = -1; busyc = 0; donec = 0; p = 'x; x = 1'bx;
    for (int k = 0; k < nk; k++) begin
      @(negedge clk);
      if (b8.Busy) busyc++;
      if (b8.Done) begin
        donec++;
        if (lat < 0) begin
          lat = k; p = b8.Product; x = b8.X;
        end
      end
      if (k + 1 >= hold) b8.Start = 1'b0;
      b8.Multiplicand = 8'($urandom);
      b8.Multiplier   = 8'($urandom);
      b8.Signed_Mode  = 1'($urandom);
      b8.Chain        = 1'($urandom);
    end
    pend = b8.Product;
  endtask

  task automatic op4(input bit sm, input bit ch,
                     input logic [3:0] mc, input logic [3:0] mr,
                     output logic [7:0] p, output int lat,
                     output int busyc, output int donec,
                     output logic [7:0] pend);
    @(negedge clk);
    b4.Start = 1'b1; b4.Signed_Mode = sm; b4.Chain = ch;
    b4.Multiplicand = mc; b4.Multiplier = mr;
    @(posedge clk);
    lat = -1; busyc = 0; donec = 0; p = 'x;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (b4.Busy) busyc++;
      if (b4.Done) begin
        donec++;
        if (lat < 0) begin
          lat = k; p = b4.Product;
        end
      end
      b4.Start = 1'b0;
      b4.Multiplicand = 4'($urandom);
      b4.Multiplier   = 4'($urandom);
      b4.Signed_Mode  = 1'($urandom);
      b4.Chain        = 1'($urandom);
    end
    pend = b4.Product;
  endtask

  task automatic test_reset;
    b8.Start = 0; b8.Signed_Mode = 0; b8.Chain = 0;
    b8.Multiplicand = 0; b8.Multiplier = 0;
    b4.Start = 0; b4.Signed_Mode = 0; b4.Chain = 0;
    b4.Multiplicand = 0; b4.Multiplier = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({b8.Busy, b8.Done, b8.X, b8.Product} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset8 got %b/%b/%b/%h want 0", b8.Busy, b8.Done, b8.X, b8.Product);
    end
    n_chk++;
    if ({b4.Busy, b4.Done, b4.X, b4.Product} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset4 got %b/%b/%b/%h want 0", b4.Busy, b4.Done, b4.X, b4.Product);
    end
    rst_n = 1'b1;
    mb8 = '0; mb4 = '0;
  endtask

  task automatic test_signed_latency;
    logic [15:0] p, pe; logic x; int lat, bc, dc;
    op8(1, 0, 8'h07, 8'hC5, 1, 24, p, x, lat, bc, dc, pe);
    mb8 = 8'h63;
    n_chk++;
    if (p !== 16'hFE63) begin n_fail++; $display("FAIL s7x-59 product got %h want FE63", p); end
    n_chk++;
    if (lat !== 17) begin n_fail++; $display("FAIL s7x-59 latency got %0d want 17", lat); end
    n_chk++;
    if (bc !== 16) begin n_fail++; $display("FAIL s7x-59 busy got %0d want 16", bc); end
    n_chk++;
    if (dc !== 1) begin n_fail++; $display("FAIL s7x-59 dones got %0d want 1", dc); end
  endtask

  task automatic test_corners;
    logic [15:0] p, pe; logic x; int lat, bc, dc;
    bit sm[3] = '{1, 1, 0};
    logic [7:0] opv[3] = '{8'h80, 8'hFF, 8'hFF};
    logic [15:0] exp[3] = '{16'h4000, 16'h0001, 16'hFE01};
    for (int i = 0; i < 3; i++) begin
      op8(sm[i], 0, opv[i], opv[i], 1, 24, p, x, lat, bc, dc, pe);
      mb8 = exp[i][7:0];
      n_chk++;
      if (p !== exp[i]) begin n_fail++; $display("FAIL corner%0d product got %h want %h", i, p, exp[i]); end
      n_chk++;
      if (x !== 1'b0) begin n_fail++; $display("FAIL corner%0d X got %b want 0", i, x); end
    end
  endtask

  task automatic test_chain;
    logic [15:0] p, pe; logic x; int lat, bc, dc;
    op8(1, 0, 8'h02, 8'h03, 1, 24, p, x, lat, bc, dc, pe);
    n_chk++;
    if (p !== 16'h0006) begin n_fail++; $display("FAIL chain_seed got %h want 0006", p); end
    op8(1, 1, 8'h02, 8'h55, 1, 24, p, x, lat, bc, dc, pe);
    mb8 = 8'h0C;
    n_chk++;
    if (p !== 16'h000C) begin n_fail++; $display("FAIL chain got %h want 000C", p); end
  endtask

  task automatic test_hold;
    logic [15:0] p, pe; logic x; int lat, bc, dc;
    op8(0, 0, 8'h05, 8'h04, 100, 110, p, x, lat, bc, dc, pe);
    mb8 = 8'h14;
    n_chk++;
    if (dc !== 1) begin n_fail++; $display("FAIL hold dones got %0d want 1", dc); end
    n_chk++;
    if (p !== 16'h0014) begin n_fail++; $display("FAIL hold product got %h want 0014", p); end
    n_chk++;
    if (pe !== 16'h0014) begin n_fail++; $display("FAIL hold stable got %h want 0014", pe); end
  endtask

  task automatic test_abort;
    logic [15:0] p, pe; logic x; int lat, bc, dc;
    @(negedge clk);
    b8.Start = 1; b8.Signed_Mode = 0; b8.Chain = 0;
    b8.Multiplicand = 8'h7F; b8.Multiplier = 8'h7F;
    @(posedge clk);
    b8.Start = 0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({b8.Busy, b8.Done, b8.Product} !== 18'd0) begin
      n_fail++;
      $display("FAIL abort got %b/%b/%h want 0/0/0000", b8.Busy, b8.Done, b8.Product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mb4 = '0;
    op8(0, 0, 8'h7F, 8'h7F, 1, 24, p, x, lat, bc, dc, pe);
    mb8 = 8'h01;
    n_chk++;
    if (p !== 16'h3F01 || lat !== 17) begin
      n_fail++; $display("FAIL after_abort got %h lat %0d want 3F01 lat 17", p, lat);
    end
  endtask

  task automatic test_width4;
    logic [7:0] p, pe; int lat, bc, dc;
    op4(1, 0, 4'h8, 4'h7, p, lat, bc, dc, pe);
    mb4 = p;
    n_chk++;
    if (p !== 8'hC8 || lat !== 9 || bc !== 8) begin
      n_fail++; $display("FAIL w4_signed got %h lat %0d busy %0d want C8 9 8", p, lat, bc);
    end
    op4(0, 0, 4'hF, 4'hF, p, lat, bc, dc, pe);
    mb4 = 4'h1;
    n_chk++;
    if (p !== 8'hE1) begin n_fail++; $display("FAIL w4_unsigned got %h want E1", p); end
  endtask

  task automatic test_random;
    logic [15:0] p, pe, e; logic x; int lat, bc, dc;
    logic [7:0] p4, pe4, e4;
    bit sm, ch; logic [7:0] a, b;
    for (int i = 0; i < 30; i++) begin
      sm = 1'($urandom); ch = ($urandom_range(3) == 0);
      a = 8'($urandom); b = 8'($urandom);
      e = ref8(sm, a, ch ? mb8 : b);
      op8(sm, ch, a, b, 1, 22, p, x, lat, bc, dc, pe);
      mb8 = e[7:0];
      n_chk++;
      if (p !== e || pe !== e || lat !== 17 || dc !== 1 || bc !== 16) begin
        n_fail++;
        $display("FAIL rand8 #%0d got %h/%h lat %0d done %0d want %h lat 17", i, p, pe, lat, dc, e);
      end
      n_chk++;
      if (x !== (sm & e[15])) begin
        n_fail++; $display("FAIL rand8_x #%0d got %b want %b", i, x, sm & e[15]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      sm = 1'($urandom); ch = ($urandom_range(3) == 0);
      a = 8'($urandom); b = 8'($urandom);
      e4 = ref4(sm, a[3:0], ch ? mb4 : b[3:0]);
      op4(sm, ch, a[3:0], b[3:0], p4, lat, bc, dc, pe4);
      mb4 = e4[3:0];
      n_chk++;
      if (p4 !== e4 || pe4 !== e4 || lat !== 9 || dc !== 1) begin
        n_fail++;
        $display("FAIL rand4 #%0d got %h/%h lat %0d done %0d want %h lat 9", i, p4, pe4, lat, dc, e4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_latency();
    test_corners();
    test_chain();
    test_hold();
    test_abort();
    test_width4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised sequential add-shift multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Runtime selection of signed (two's complement) or unsigned operation.
- Chain mode: the previous product's low half becomes the next multiplier.
- Start/Busy/Done handshake so a core FSM or button front end (already synchronised) can drive it; result is held stable until the next accepted Start.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CW, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  level request; accepted per Behaviour.
- Signed_Mode  input  1  1 = signed operands, 0 = unsigned; sampled at accept.
- Chain  input  1  1 = multiplier taken from current B register instead of Multiplier; sampled at accept.
- Multiplicand  input  WIDTH  sampled at accept, held internally.
- Multiplier  input  WIDTH  sampled at accept unless Chain=1.
- Busy  output  1  high while computing.
- Done  output  1  one-cycle pulse when Product becomes valid.
- Product  output  2*WIDTH  {A,B}; holds the last result.
- X  output  1  sign/carry extension bit of A.

Behaviour:
- Reset (Reset=0, async): state IDLE; A, B, X, counter, Busy, Done = 0; Product = 0. Reset deasserts synchronously to logic (no glitch on first edge). Reset mid-operation aborts immediately; no Done is produced.
- States: IDLE, ADD, SHIFT, HOLD.
- IDLE: Start=1 -> accept.
  - Latch M = Multiplicand and mode.
  - B = Chain ? B : Multiplier; A = 0; X = 0; cnt = 0.
  - Busy=1 next cycle; go to ADD.
- ADD (cnt = 0..WIDTH-1):
  - If B[0]=1, {X,A} = ext(A) + ext(M), where ext is sign-extension if Signed_Mode, else zero-extension, to WIDTH+1 bits.
  - Signed_Mode=1 and cnt = WIDTH-1: subtract instead ({X,A} = ext(A) - ext(M)).
  - B[0]=0: {X,A} unchanged; the state is still occupied, so latency is constant.
  - Go to SHIFT.
- SHIFT: {X,A,B} shifted right 1.
  - New X = Signed_Mode ? X : 0.
  - New A[WIDTH-1] = X.
  - B[WIDTH-1] = old A[0].
  - cnt++. cnt reaching WIDTH -> HOLD, else ADD.
- HOLD:
  - On entry: Done=1 for exactly one cycle; Busy=0.
  - Exit to IDLE only when Start=0; a Start held high never launches a second operation.
- Latency: Start accepted at edge 0; Done asserted after edge 2*WIDTH+1; Product valid the same cycle and stable until the next accept.
- Start, Multiplicand, Multiplier, Signed_Mode and Chain are ignored while Busy=1 or in HOLD. Input changes mid-operation have no effect.
- Unsigned: carry out of the add lands in X, then shifts into A MSB; full 2*WIDTH result exact.
- Signed: result exact for all operands, including (-2^(WIDTH-1))^2.
- Chain with Signed_Mode change between operations is legal; B is reinterpreted under the new mode.
- Counter must not wrap: cnt is CW+1 bits or the terminal compare is done before increment.

Test Plan:
- WIDTH=8, signed, 0x07 * 0xC5 (7 * -59) -> Product=0xFE63, Done pulse exactly 17 cycles after accept, Busy high 16 cycles.
- WIDTH=8, signed, 0x80 * 0x80 -> 0x4000; 0xFF * 0xFF -> 0x0001; unsigned 0xFF * 0xFF -> 0xFE01, X=0 in HOLD.
- WIDTH=8, signed, 0x02 * 0x03 -> 0x0006. Release Start, then Chain=1, Multiplicand=0x02, Multiplier=0x55 -> 0x000C (0x55 ignored).
- Start held high 100 cycles, operands 0x05 * 0x04 -> exactly one Done pulse, Product=0x0014. Changing operands while in HOLD leaves Product unchanged.
- Reset low at cycle 6 of 0x7F * 0x7F -> Busy=0, Done=0, Product=0x0000 immediately. After release, a new 0x7F * 0x7F -> 0x3F01.
- WIDTH=4, signed, 0x8 * 0x7 -> 0xC8 after 9 cycles; WIDTH=4, unsigned, 0xF * 0xF -> 0xE1.
